pipe_stage_reg: RTL and testbench

Parametrised, generalised pipeline boundary register for the five-stage datapath; it replaces the fixed ID/EX-style register.
- Carries a valid bit, NUM_DATA data words, three control groups (WB/MEM/EX) and NUM_REG register-number fields.
- Adds stall (hold), flush (bubble insertion), a selectable half-cycle output mode, and saturating stall/bubble counters for hazard-unit debug.
- The same module is instanced at every stage boundary (IF/ID, ID/EX, EX/MEM, MEM/WB).

---
 rtl/pipe_stage_reg_pkg.sv | 26 ++
 rtl/pipe_stage_reg_sat_counter.sv | 32 +++
 rtl/pipe_stage_reg.sv | 154 +++++++++++++++
 tb/tb_pipe_stage_reg.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/pipe_stage_reg_pkg.sv
// Shared widths, bubble control encodings and per-boundary sizing for the
// five-stage datapath pipeline registers.
package pipe_pkg;

   localparam int DATA_W_DEF     = 32;
   localparam int REG_W_DEF      = 5;
   localparam int CTRL_WB_W_DEF  = 2;
   localparam int CTRL_MEM_W_DEF = 3;
   localparam int CTRL_EX_W_DEF  = 4;
   localparam int CNT_W_DEF      = 16;

   // A bubble carries all-zero controls so it can never write or access memory.
   localparam logic [CTRL_WB_W_DEF-1:0]  CTRL_WB_NOP  = '0;
   localparam logic [CTRL_MEM_W_DEF-1:0] CTRL_MEM_NOP = '0;
   localparam logic [CTRL_EX_W_DEF-1:0]  CTRL_EX_NOP  = '0;

   localparam int IFID_NUM_DATA  = 2;
   localparam int IFID_NUM_REG   = 1;
   localparam int IDEX_NUM_DATA  = 4;
   localparam int IDEX_NUM_REG   = 2;
   localparam int EXMEM_NUM_DATA = 3;
   localparam int EXMEM_NUM_REG  = 1;
   localparam int MEMWB_NUM_DATA = 2;
   localparam int MEMWB_NUM_REG  = 1;

endpackage

// File: rtl/pipe_stage_reg_sat_counter.sv
// Saturating up-counter with synchronous active-low clear; used for the
// hazard-unit stall and bubble statistics.
module sat_counter
   import pipe_pkg::*;
#(
   parameter int CNT_W = CNT_W_DEF
) (
   input  logic             clk_i,
   input  logic             clr_n_i,
   input  logic             inc_i,
   output logic [CNT_W-1:0] count_o
);

   logic [CNT_W-1:0] count_q;
   logic [CNT_W-1:0] count_d;

   always_comb begin
      count_d = count_q;
      if (inc_i && (count_q != {CNT_W{1'b1}}))
         count_d = count_q + CNT_W'(1);
   end

   always_ff @(posedge clk_i) begin
      if (!clr_n_i)
         count_q <= '0;
      else
         count_q <= count_d;
   end

   assign count_o = count_q;

endmodule

// File: rtl/pipe_stage_reg.sv
// Generic pipeline boundary register: valid, data words, WB/MEM/EX controls and
// register numbers, with flush/stall, optional negedge output stage and debug counters.
module pipe_stage_reg
   import pipe_pkg::*;
#(
   parameter int DATA_W         = DATA_W_DEF,
   parameter int NUM_DATA       = IDEX_NUM_DATA,
   parameter int CTRL_WB_W      = CTRL_WB_W_DEF,
   parameter int CTRL_MEM_W     = CTRL_MEM_W_DEF,
   parameter int CTRL_EX_W      = CTRL_EX_W_DEF,
   parameter int REG_W          = REG_W_DEF,
   parameter int NUM_REG        = IDEX_NUM_REG,
   parameter bit HALF_CYCLE_OUT = 1'b1,
   parameter int CNT_W          = CNT_W_DEF
) (
   input  logic                       Clk,
   input  logic                       Rst_n,
   input  logic                       Stall_In,
   input  logic                       Flush_In,
   input  logic                       Valid_In,
   input  logic [NUM_DATA*DATA_W-1:0] Data_In,
   input  logic [CTRL_WB_W-1:0]       CtrlWB_In,
   input  logic [CTRL_MEM_W-1:0]      CtrlMEM_In,
   input  logic [CTRL_EX_W-1:0]       CtrlEX_In,
   input  logic [NUM_REG*REG_W-1:0]   RegNum_In,
   output logic                       Valid_Out,
   output logic [NUM_DATA*DATA_W-1:0] Data_Out,
   output logic [CTRL_WB_W-1:0]       CtrlWB_Out,
   output logic [CTRL_MEM_W-1:0]      CtrlMEM_Out,
   output logic [CTRL_EX_W-1:0]       CtrlEX_Out,
   output logic [NUM_REG*REG_W-1:0]   RegNum_Out,
   output logic [CNT_W-1:0]           StallCount_Out,
   output logic [CNT_W-1:0]           BubbleCount_Out
);

   localparam int DW = NUM_DATA * DATA_W;
   localparam int RW = NUM_REG * REG_W;

   logic                  valid_q, valid_d;
   logic [DW-1:0]         data_q, data_d;
   logic [CTRL_WB_W-1:0]  wb_q, wb_d;
   logic [CTRL_MEM_W-1:0] mem_q, mem_d;
   logic [CTRL_EX_W-1:0]  ex_q, ex_d;
   logic [RW-1:0]         regnum_q, regnum_d;

   // Flush beats stall; a flush still loads data/regnum so the bubble content is deterministic.
   always_comb begin
      valid_d  = valid_q;
      data_d   = data_q;
      wb_d     = wb_q;
      mem_d    = mem_q;
      ex_d     = ex_q;
      regnum_d = regnum_q;
      if (Flush_In) begin
         valid_d  = 1'b0;
         data_d   = Data_In;
         wb_d     = CTRL_WB_W'(CTRL_WB_NOP);
         mem_d    = CTRL_MEM_W'(CTRL_MEM_NOP);
         ex_d     = CTRL_EX_W'(CTRL_EX_NOP);
         regnum_d = RegNum_In;
      end else if (!Stall_In) begin
         valid_d  = Valid_In;
         data_d   = Data_In;
         wb_d     = Valid_In ? CtrlWB_In  : CTRL_WB_W'(CTRL_WB_NOP);
         mem_d    = Valid_In ? CtrlMEM_In : CTRL_MEM_W'(CTRL_MEM_NOP);
         ex_d     = Valid_In ? CtrlEX_In  : CTRL_EX_W'(CTRL_EX_NOP);
         regnum_d = RegNum_In;
      end
   end

   always_ff @(posedge Clk) begin
      if (!Rst_n) begin
         valid_q  <= 1'b0;
         data_q   <= '0;
         wb_q     <= '0;
         mem_q    <= '0;
         ex_q     <= '0;
         regnum_q <= '0;
      end else begin
         valid_q  <= valid_d;
         data_q   <= data_d;
         wb_q     <= wb_d;
         mem_q    <= mem_d;
         ex_q     <= ex_d;
         regnum_q <= regnum_d;
      end
   end

   generate
      if (HALF_CYCLE_OUT) begin : g_half_cycle
         logic                  valid_o_q;
         logic [DW-1:0]         data_o_q;
         logic [CTRL_WB_W-1:0]  wb_o_q;
         logic [CTRL_MEM_W-1:0] mem_o_q;
         logic [CTRL_EX_W-1:0]  ex_o_q;
         logic [RW-1:0]         regnum_o_q;

         // Next stage sees the captured value half a cycle after the posedge.
         always_ff @(negedge Clk) begin
            if (!Rst_n) begin
               valid_o_q  <= 1'b0;
               data_o_q   <= '0;
               wb_o_q     <= '0;
               mem_o_q    <= '0;
               ex_o_q     <= '0;
               regnum_o_q <= '0;
            end else begin
               valid_o_q  <= valid_q;
               data_o_q   <= data_q;
               wb_o_q     <= wb_q;
               mem_o_q    <= mem_q;
               ex_o_q     <= ex_q;
               regnum_o_q <= regnum_q;
            end
         end

         assign Valid_Out   = valid_o_q;
         assign Data_Out    = data_o_q;
         assign CtrlWB_Out  = wb_o_q;
         assign CtrlMEM_Out = mem_o_q;
         assign CtrlEX_Out  = ex_o_q;
         assign RegNum_Out  = regnum_o_q;
      end else begin : g_direct
         assign Valid_Out   = valid_q;
         assign Data_Out    = data_q;
         assign CtrlWB_Out  = wb_q;
         assign CtrlMEM_Out = mem_q;
         assign CtrlEX_Out  = ex_q;
         assign RegNum_Out  = regnum_q;
      end
   endgenerate

   logic stall_inc;
   logic bubble_inc;

   // Only stalls that actually hold a live instruction count toward stall cycles.
   assign stall_inc  = Stall_In & ~Flush_In & valid_q;
   assign bubble_inc = Flush_In | (~Stall_In & ~Valid_In);

   sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
      .clk_i   (Clk),
      .clr_n_i (Rst_n),
      .inc_i   (stall_inc),
      .count_o (StallCount_Out)
   );

   sat_counter #(.CNT_W(CNT_W)) u_bubble_cnt (
      .clk_i   (Clk),
      .clr_n_i (Rst_n),
      .inc_i   (bubble_inc),
      .count_o (BubbleCount_Out)
   );

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Scoreboard bench: default ID/EX instance, a 3-bit-counter instance and a
// NUM_DATA=2/NUM_REG=3 direct-output instance, all driven from one stimulus stream.
module tb_pipe_stage_reg;

   typedef struct packed {
      logic         valid;
      logic [127:0] data;
      logic [1:0]   wb;
      logic [2:0]   mem;
      logic [3:0]   ex;
      logic [9:0]   rn;
      logic [14:0]  rn2;
      logic [15:0]  sc;
      logic [15:0]  bc;
      logic [2:0]   sc3;
      logic [2:0]   bc3;
   } exp_t;

   logic         Clk;
   logic         rst_n, stall, flush, valid;
   logic [127:0] data_in;
   logic [1:0]   wb_in;
   logic [2:0]   mem_in;
   logic [3:0]   ex_in;
   logic [9:0]   rn_in;
   logic [14:0]  rn2_in;

   logic         d0_valid, d1_valid, d2_valid;
   logic [127:0] d0_data, d1_data;
   logic [63:0]  d2_data;
   logic [1:0]   d0_wb, d1_wb, d2_wb;
   logic [2:0]   d0_mem, d1_mem, d2_mem;
   logic [3:0]   d0_ex, d1_ex, d2_ex;
   logic [9:0]   d0_rn, d1_rn;
   logic [14:0]  d2_rn;
   logic [15:0]  d0_sc, d0_bc, d2_sc, d2_bc;
   logic [2:0]   d1_sc, d1_bc;

   int n_total = 0;
   int n_bad   = 0;
   int n_step  = 0;
   exp_t exp_q[$];

   logic         m_valid;
   logic [127:0] m_data;
   logic [1:0]   m_wb;
   logic [2:0]   m_mem;
   logic [3:0]   m_ex;
   logic [9:0]   m_rn;
   logic [14:0]  m_rn2;
   logic [15:0]  m_sc, m_bc;
   logic [2:0]   m_sc3, m_bc3;

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   pipe_stage_reg dut0 (
      .Clk(Clk), .Rst_n(rst_n), .Stall_In(stall), .Flush_In(flush), .Valid_In(valid),
      .Data_In(data_in), .CtrlWB_In(wb_in), .CtrlMEM_In(mem_in), .CtrlEX_In(ex_in),
      .RegNum_In(rn_in), .Valid_Out(d0_valid), .Data_Out(d0_data), .CtrlWB_Out(d0_wb),
      .CtrlMEM_Out(d0_mem), .CtrlEX_Out(d0_ex), .RegNum_Out(d0_rn),
      .StallCount_Out(d0_sc), .BubbleCount_Out(d0_bc)
   );

   pipe_stage_reg #(.CNT_W(3)) dut1 (
      .Clk(Clk), .Rst_n(rst_n), .Stall_In(stall), .Flush_In(flush), .Valid_In(valid),
      .Data_In(data_in), .CtrlWB_In(wb_in), .CtrlMEM_In(mem_in), .CtrlEX_In(ex_in),
      .RegNum_In(rn_in), .Valid_Out(d1_valid), .Data_Out(d1_data), .CtrlWB_Out(d1_wb),
      .CtrlMEM_Out(d1_mem), .CtrlEX_Out(d1_ex), .RegNum_Out(d1_rn),
      .StallCount_Out(d1_sc), .BubbleCount_Out(d1_bc)
   );

   pipe_stage_reg #(.NUM_DATA(2), .NUM_REG(3), .HALF_CYCLE_OUT(1'b0)) dut2 (
      .Clk(Clk), .Rst_n(rst_n), .Stall_In(stall), .Flush_In(flush), .Valid_In(valid),
      .Data_In(data_in[63:0]), .CtrlWB_In(wb_in), .CtrlMEM_In(mem_in), .CtrlEX_In(ex_in),
      .RegNum_In(rn2_in), .Valid_Out(d2_valid), .Data_Out(d2_data), .CtrlWB_Out(d2_wb),
      .CtrlMEM_Out(d2_mem), .CtrlEX_Out(d2_ex), .RegNum_Out(d2_rn),
      .StallCount_Out(d2_sc), .BubbleCount_Out(d2_bc)
   );

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp_v);
      n_total++;
      if (obs !== exp_v) begin
         n_bad++;
         $display("FAIL %s: got %0h want %0h", tag, obs, exp_v);
      end
   endtask

   // Checks the direct-output instance one posedge later and the half-cycle
   // instances at the following negedge.
   task automatic step(input logic r, input logic s, input logic f, input logic v,
                       input logic [127:0] d, input logic [1:0] wb, input logic [2:0] mem,
                       input logic [3:0] ex, input logic [9:0] rn, input logic [14:0] rn2);
      exp_t e;
      logic sinc, binc;
      rst_n = r; stall = s; flush = f; valid = v;
      data_in = d; wb_in = wb; mem_in = mem; ex_in = ex; rn_in = rn; rn2_in = rn2;

      if (!r) begin
         m_valid = 1'b0; m_data = '0; m_wb = '0; m_mem = '0; m_ex = '0;
         m_rn = '0; m_rn2 = '0; m_sc = '0; m_bc = '0; m_sc3 = '0; m_bc3 = '0;
      end else begin
         sinc = s & ~f & m_valid;
         binc = f | (~s & ~v);
         if (sinc && m_sc  != 16'hFFFF) m_sc  = m_sc + 16'd1;
         if (binc && m_bc  != 16'hFFFF) m_bc  = m_bc + 16'd1;
         if (sinc && m_sc3 != 3'd7)     m_sc3 = m_sc3 + 3'd1;
         if (binc && m_bc3 != 3'd7)     m_bc3 = m_bc3 + 3'd1;
         if (f) begin
            m_valid = 1'b0; m_wb = '0; m_mem = '0; m_ex = '0;
            m_data = d; m_rn = rn; m_rn2 = rn2;
         end else if (!s) begin
            m_valid = v; m_data = d; m_rn = rn; m_rn2 = rn2;
            m_wb  = v ? wb  : 2'b0;
            m_mem = v ? mem : 3'b0;
            m_ex  = v ? ex  : 4'b0;
         end
      end
      e = '{valid: m_valid, data: m_data, wb: m_wb, mem: m_mem, ex: m_ex, rn: m_rn,
            rn2: m_rn2, sc: m_sc, bc: m_bc, sc3: m_sc3, bc3: m_bc3};
      exp_q.push_back(e);

      @(posedge Clk); #1;
      e = exp_q.pop_front();
      chk("d2_valid", d2_valid, e.valid);
      chk("d2_data",  d2_data,  e.data[63:0]);
      chk("d2_ctrl",  {d2_wb, d2_mem, d2_ex}, {e.wb, e.mem, e.ex});
      chk("d2_rn",    d2_rn,    e.rn2);
      chk("d2_rn_f2", d2_rn[14:10], e.rn2[14:10]);
      chk("d2_cnt",   {d2_sc, d2_bc}, {e.sc, e.bc});

      @(negedge Clk); #1;
      chk("d0_valid", d0_valid, e.valid);
      chk("d0_data",  d0_data,  e.data);
      chk("d0_wb",    d0_wb,    e.wb);
      chk("d0_mem",   d0_mem,   e.mem);
      chk("d0_ex",    d0_ex,    e.ex);
      chk("d0_rn",    d0_rn,    e.rn);
      chk("d0_stall", d0_sc,    e.sc);
      chk("d0_bubble",d0_bc,    e.bc);
      chk("d1_out",   {d1_valid, d1_data, d1_wb, d1_mem, d1_ex, d1_rn} != 0,
                      {e.valid, e.data, e.wb, e.mem, e.ex, e.rn} != 0);
      chk("d1_stall", d1_sc,    e.sc3);
      chk("d1_bubble",d1_bc,    e.bc3);
      chk("d2_neg_stable", {d2_valid, d2_data, d2_rn}, {e.valid, e.data[63:0], e.rn2});
      n_step++;
      $display("step %0d: rst_n=%0b stall=%0b flush=%0b valid=%0b -> vout=%0b stall_cnt=%0d bubble_cnt=%0d bad=%0d",
               n_step, r, s, f, v, d0_valid, d0_sc, d0_bc, n_bad);
   endtask

   initial begin
      logic [127:0] w;
      // reset held two cycles with busy inputs
      step(0, 0, 0, 1, {128{1'b1}}, 2'b11, 3'b111, 4'hF, 10'h3FF, 15'h7FFF);
      step(0, 1, 1, 1, {4{32'hA5A5_5A5A}}, 2'b10, 3'b101, 4'h5, 10'h155, 15'h2AAA);
      // first load after reset
      w = {96'h0, 32'h0040_0004};
      step(1, 0, 0, 1, w, 2'b01, 3'b010, 4'hA, {5'd2, 5'd1}, {5'd31, 5'd3, 5'd7});
      // stall holds DEADBEEF while inputs change
      w = {64'h0, 32'hDEAD_BEEF, 32'h0};
      step(1, 0, 0, 1, w, 2'b10, 3'b001, 4'h3, {5'd9, 5'd8}, {5'd4, 5'd5, 5'd6});
      for (int i = 0; i < 3; i++)
         step(1, 1, 0, 1, {4{32'h1111_0000 + 32'(i)}}, 2'(i), 3'(i), 4'(i), 10'(i), 15'(i));
      // flush with stall: flush wins
      step(1, 1, 1, 1, {4{32'hCAFE_F00D}}, 2'b11, 3'b111, 4'hF, {5'd12, 5'd13}, {5'd1, 5'd2, 5'd3});
      // invalid input forces controls to zero
      step(1, 0, 0, 0, {4{32'h1234_5678}}, 2'b01, 3'b101, 4'h6, {5'd17, 5'd30}, {5'd31, 5'd0, 5'd31});
      // stall with no live instruction does not count
      step(1, 1, 0, 1, {4{32'h0BAD_0BAD}}, 2'b11, 3'b011, 4'h1, 10'h2A, 15'h1234);
      // ten flushes saturate the 3-bit bubble counter
      for (int i = 0; i < 10; i++)
         step(1, i[0], 1, 1, {4{32'hF1F1_0000 + 32'(i)}}, 2'b11, 3'b111, 4'hC, 10'(i * 7), 15'(i * 99));
      // reset in the middle of a stall clears everything
      step(0, 1, 0, 1, {4{32'h7777_7777}}, 2'b11, 3'b111, 4'hF, 10'h3FF, 15'h7FFF);
      step(1, 0, 0, 1, {4{32'h0000_1000}}, 2'b10, 3'b100, 4'h9, {5'd3, 5'd4}, {5'd31, 5'd1, 5'd2});
      // mixed traffic
      for (int i = 0; i < 24; i++) begin
         logic rs, rf;
         rs = ($urandom_range(0, 2) == 0);
         rf = ($urandom_range(0, 4) == 0);
         step(1, rs, rf, 1'($urandom), {$urandom, $urandom, $urandom, $urandom},
              2'($urandom), 3'($urandom), 4'($urandom), 10'($urandom), 15'($urandom));
      end
      if (exp_q.size() != 0) chk("queue_empty", 128'(exp_q.size()), 128'd0);
      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
